// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Width of a client index; a single client still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module mem_rr_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan clients starting at ptr; the first one requesting wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            idx = sum[PW-1:0];
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between several clients.
//
// Handshakes: a client raises cl_req (with w_en/addr/wdata stable) and holds
// it until it sees its one-cycle cl_ack; the memory side sees mem_req held
// with stable controls until a one-cycle mem_ack, or until the wait counter
// reaches TIMEOUT, in which case the client gets cl_ack together with cl_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    input  logic [NUM_CLIENTS-1:0]        cl_w_en,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
    output logic [NUM_CLIENTS-1:0]        cl_ack,
    output logic [DATA_W-1:0]             cl_rdata,
    output logic                          cl_err,
    output logic                          mem_req,
    output logic                          mem_w_en,
    output logic [ADDR_W-1:0]             mem_addr,
    inout  wire  [DATA_W-1:0]             mem_data,
    input  logic                          mem_ack,
    output logic [1:0]                    dbg_state,
    output logic                          bus_drive
);

    localparam int PW = ptr_width(NUM_CLIENTS);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t        state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     winner_q;
    logic              any_req;
    logic [CW-1:0]     wait_cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              sel_w_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    mem_rr_picker #(
        .N  (NUM_CLIENTS),
        .PW (PW)
    ) u_picker (
        .req    (cl_req),
        .ptr    (rr_ptr),
        .winner (pick),
        .any    (any_req)
    );

    // Mux out the request fields of the client the picker chose.
    always_comb begin
        sel_w_en  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pick == PW'(i)) begin
                sel_w_en  = cl_w_en[i];
                sel_addr  = cl_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = cl_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration FSM with registered memory- and client-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            winner_q <= '0;
            wait_cnt <= '0;
            wdata_q  <= '0;
            mem_req  <= 1'b0;
            mem_w_en <= 1'b0;
            mem_addr <= '0;
            cl_ack   <= '0;
            cl_err   <= 1'b0;
            cl_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner_q <= pick;
                        mem_w_en <= sel_w_en;
                        mem_addr <= sel_addr;
                        wdata_q  <= sel_wdata;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack || (wait_cnt == CW'(TIMEOUT))) begin
                        if (mem_ack && !mem_w_en) begin
                            cl_rdata <= mem_data;
                        end
                        mem_req <= 1'b0;
                        cl_ack  <= NUM_CLIENTS'(1) << winner_q;
                        cl_err  <= !mem_ack;
                        rr_ptr  <= (winner_q == PW'(NUM_CLIENTS - 1)) ? '0 : winner_q + 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    cl_ack <= '0;
                    cl_err <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The bus is only ours while a write is outstanding.
    assign bus_drive = (state == BUSY) && mem_w_en;
    assign mem_data  = bus_drive ? wdata_q : {DATA_W{1'bz}};
    assign dbg_state = state;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 3: number of requesters sharing one memory port.
REQ-002 Parameter ADDR_W, default 16: address width.
REQ-003 Parameter DATA_W, default 256: data width.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack before aborting.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 Port reset_n, input, 1: asynchronous active-low reset.
REQ-008 Port cl_req, input, NUM_CLIENTS: per-client request, held high until that client's ack.
REQ-009 Port cl_w_en, input, NUM_CLIENTS: per-client write enable (1 = write, 0 = read).
REQ-010 Port cl_addr, input, NUM_CLIENTS x ADDR_W: per-client address.
REQ-011 Port cl_wdata, input, NUM_CLIENTS x DATA_W: per-client write data.
REQ-012 Port cl_ack, output, NUM_CLIENTS: per-client one-cycle completion pulse.
REQ-013 Port cl_rdata, output, DATA_W: read data, valid in the cycle where any cl_ack bit is high.
REQ-014 Port cl_err, output, 1: high with cl_ack when the transaction timed out.
REQ-015 Port mem_req, output, 1: request to the memory slave.
REQ-016 Port mem_w_en, output, 1: write enable to the memory slave.
REQ-017 Port mem_addr, output, ADDR_W: address to the memory slave.
REQ-018 Port mem_data, inout, DATA_W: shared bidirectional data bus.
REQ-019 Port mem_ack, input, 1: memory completion pulse.

Function
REQ-020 FSM states SHALL be IDLE, BUSY, DONE.
REQ-021 IDLE: if any cl_req is high, the block SHALL pick a winner by round-robin starting at rr_ptr.
  - It SHALL register that winner's w_en, addr and wdata.
  - It SHALL assert mem_req on the next cycle and go to BUSY.
REQ-022 BUSY: mem_req, mem_w_en and mem_addr SHALL be held stable.
  - The wait counter SHALL increment every cycle.
  - On mem_ack the block SHALL go to DONE.
  - If the counter reaches TIMEOUT with no mem_ack, the block SHALL go to DONE with err flagged.
REQ-023 Read capture: on mem_ack with mem_w_en=0, mem_data SHALL be latched into cl_rdata.
REQ-024 DONE, held for exactly one cycle:
  - mem_req=0.
  - cl_ack[winner]=1; all other cl_ack bits 0.
  - cl_err=err.
  - rr_ptr SHALL become (winner+1) mod NUM_CLIENTS.
  - Next state is IDLE.
REQ-025 mem_data SHALL be driven with the registered wdata only in BUSY when mem_w_en=1, and SHALL be high-Z otherwise.
REQ-026 Latency:
  - Client request sampled in IDLE at cycle 0.
  - mem_req is high from cycle 1.
  - With mem_ack at cycle k, cl_ack is high at cycle k+1 and mem_req is low at cycle k+1.
REQ-027 mem_req SHALL never be high in the same cycle as any cl_ack bit.
REQ-028 At most one transaction SHALL be outstanding at any time.
REQ-029 Once a client is granted, its transaction SHALL complete even if its cl_req falls early; no abort on client side.
REQ-030 mem_ack received in IDLE or DONE SHALL be ignored.
REQ-031 Requests arriving during BUSY or DONE SHALL wait; they are evaluated in the next IDLE cycle.
REQ-032 With all clients requesting continuously, each client SHALL be granted once per NUM_CLIENTS transactions.
REQ-033 The wait counter SHALL saturate at TIMEOUT and clear on entry to BUSY; its width is clog2(TIMEOUT+1).
REQ-034 Arbiter throughput SHALL be one transaction per (memory latency + 2) cycles.

Reset
REQ-035 While reset_n=0, regardless of clk:
  - state=IDLE, rr_ptr=0, counter=0.
  - mem_req=0, mem_w_en=0, mem_addr=0.
  - cl_ack=0, cl_err=0, cl_rdata=0.
  - mem_data high-Z.
REQ-036 Reset mid-transaction SHALL abort it silently; no cl_ack SHALL be issued for it after reset release.
REQ-037 The first IDLE cycle after reset release SHALL honour requests, with priority starting at client 0.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the ADDR_W/DATA_W defaults and the arb_state_t enum {IDLE, BUSY, DONE}.
REQ-039 One sub-module, mem_rr_picker (combinational round-robin winner from a request vector and rr_ptr, plus any-request flag), SHALL be instantiated; all other logic is in mem_arbiter.

Verification
REQ-040 Single read: client 1 reads 0x0040; memory acks 3 cycles after mem_req with data 0xA5..A5.
  - Required: cl_ack[1] pulses once, cl_rdata=0xA5..A5, cl_err=0.
REQ-041 Single write: client 0 writes 0x1234 with data 0x55..55.
  - Required: mem_w_en=1, mem_addr=0x1234 and mem_data=0x55..55 throughout BUSY; bus high-Z after.
REQ-042 Contention: all three clients request in the same cycle.
  - Required: grant order 0,1,2; a new request from client 0 is then granted before 1 and 2.
REQ-043 Timeout: mem_ack is never asserted.
  - Required: cl_ack of the winner plus cl_err pulse exactly TIMEOUT+1 cycles after mem_req rose; the next client is served afterwards.
REQ-044 Reset in BUSY: reset_n is pulled low 2 cycles into a read.
  - Required: all outputs 0 and bus high-Z immediately; no cl_ack after release; a pending request is regranted from client 0.
REQ-045 Protocol checks SHALL run throughout every scenario: cl_ack and mem_ack are single-cycle pulses, mem_req never overlaps cl_ack, and no output is X after reset.
